// File: rtl/moa_sum_accum_pkg.sv
// Shared definitions for the multi-operand adder family: adder result width,
// adder latency, operand count and the accumulator width derivation.
// Optional feature macro of moa_sum_accum: MOA_ACC_AVG_EN.
package moa_sum_accum_pkg;

  localparam int MOA_SUM_W     = 11;
  localparam int MOA_LAT_EDGES = 2;
  localparam int MOA_NUM_OPS   = 8;

  // Accumulating acc_len unsigned sums needs log2(acc_len) extra bits.
  function automatic int acc_width(input int sum_w, input int acc_len);
    return sum_w + $clog2(acc_len);
  endfunction

endpackage

// File: rtl/moa_valid_dly.sv
// Valid delay line: dout is din delayed DEPTH clock edges.
// Async active-low reset; clear empties the whole line synchronously.
module moa_valid_dly #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] line;

  // Shift din through DEPTH stages; stage 0 takes the fresh sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line <= '0;
    end else if (clear) begin
      line <= '0;
    end else begin
      line[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        line[i] <= line[i-1];
      end
    end
  end

  assign dout = line[DEPTH-1];

endmodule

// File: rtl/moa_sum_accum.sv
// Accumulates ACC_LEN aligned adder sums into one block result and presents
// it on a valid/ready output with a one-entry holding register.
// Optional feature macro: MOA_ACC_AVG_EN (output the rounded block average).
//
// Output handshake: a transfer happens on an edge where out_valid && out_ready.
// out_data is held stable while out_valid && !out_ready. A block completing
// while the register is full and not draining is dropped and sets overrun.
module moa_sum_accum
  import moa_sum_accum_pkg::*;
#(
  parameter int SUM_W   = MOA_SUM_W,
  parameter int MOA_LAT = MOA_LAT_EDGES,
  parameter int ACC_LEN = 8,
  parameter int ACC_W   = acc_width(SUM_W, ACC_LEN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [SUM_W-1:0] summ,
  input  logic             clear,
  output logic [ACC_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun
);

  localparam int CNT_W = $clog2(ACC_LEN);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(ACC_LEN - 1);

  logic             v_al;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] count;
  logic [ACC_W-1:0] final_sum;
  logic [ACC_W-1:0] result;
  logic             complete;
  logic             can_load;

  // The adder has no valid; rebuild alignment from the operand-side valid.
  moa_valid_dly #(
    .DEPTH (MOA_LAT)
  ) u_valid_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .din   (in_valid),
    .dout  (v_al)
  );

  // Block sum, completion detect and the value presented for a finished block.
  always_comb begin
    final_sum = acc + ACC_W'(summ);
    complete  = v_al && (count == LAST) && !clear;
    can_load  = !out_valid || out_ready;
`ifdef MOA_ACC_AVG_EN
    result = (final_sum + ACC_W'(ACC_LEN / 2)) >> CNT_W;
`else
    result = final_sum;
`endif
  end

  // Accumulator and sample counter; clear wins over completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      count <= '0;
    end else if (clear) begin
      acc   <= '0;
      count <= '0;
    end else if (v_al) begin
      if (count == LAST) begin
        acc   <= '0;
        count <= '0;
      end else begin
        acc   <= final_sum;
        count <= count + 1'b1;
      end
    end
  end

  // One-entry output register with valid/ready handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (complete && can_load) begin
      out_data  <= result;
      out_valid <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Sticky drop flag, cleared only by reset or clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else if (clear) begin
      overrun <= 1'b0;
    end else if (complete && !can_load) begin
      overrun <= 1'b1;
    end
  end

endmodule

// File: doc/moa_sum_accum.md
Name: moa_sum_accum

Overview:
Downstream consumer of the 8-operand pipelined multi-operand adder's 11-bit `summ` stream.
- The adder carries no valid signal. This block rebuilds valid alignment with an MOA_LAT-deep delay line driven by the operand-side valid.
- It accumulates ACC_LEN aligned sums into one block result.
- It presents each block result on a valid/ready output with a one-entry holding register.

Parameters:
- SUM_W, 11, width of the adder's `summ` output.
- MOA_LAT, 2, adder latency in clock edges, from operands sampled to `summ` valid (≥1).
- ACC_LEN, 8, number of sums per block; power of two, ≥2.
- ACC_W, SUM_W+$clog2(ACC_LEN) (=14), accumulator and output width; overflow is impossible by construction.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  high in the same cycle the operands x0..x7 are presented to the adder.
- summ  in  SUM_W  adder result, unsigned.
- clear  in  1  synchronous flush of the accumulation in progress.
- out_data  out  ACC_W  block result.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts out_data.
- overrun  out  1  sticky flag: a completed block was dropped.

Behaviour:
- Reset: out_data=0, out_valid=0, overrun=0, accumulator=0, count=0, delay line all 0. Reset is honoured mid-block and mid-handshake; the partial block is discarded.
- Delay line: MOA_LAT registers; v_al = in_valid delayed MOA_LAT edges. If in_valid is sampled at edge k, its summ is sampled at edge k+MOA_LAT.
- State ACC:
  - At an edge with v_al=1 and count<ACC_LEN-1: acc += summ (zero-extended), count++.
  - At an edge with v_al=1 and count==ACC_LEN-1 (block complete): final = acc+summ; acc<=0; count<=0.
  - At an edge with v_al=0: hold acc and count. Gaps in in_valid are allowed.
- Block completion, output side:
  - If the output register is empty, or is being drained on this edge (out_valid && out_ready): out_data<=final, out_valid<=1.
  - If out_valid=1 and out_ready=0: final is dropped, out_data is unchanged, overrun<=1.
- Output handshake:
  - A transfer occurs at an edge with out_valid && out_ready. out_valid then falls unless a new block completes on the same edge, in which case it stays 1 with the new data.
  - out_data is stable while out_valid && !out_ready.
- Latency: a contiguous burst whose first in_valid is sampled at edge k gives out_valid high after edge k+MOA_LAT+ACC_LEN-1 (k+9 at defaults).
- clear:
  - At an edge with clear=1: acc<=0, count<=0, delay line<=0, overrun<=0. The current v_al sample is discarded.
  - out_valid and out_data are unaffected; a pending result still drains.
  - clear takes priority over block completion on the same edge.
- Wrap-around: count wraps ACC_LEN-1→0 on completion only.
- Arithmetic: unsigned throughout.

Optional Feature:
- Macro: MOA_ACC_AVG_EN.
- Defined: out_data = round-half-up of final/ACC_LEN, i.e. (final + ACC_LEN/2) >> log2(ACC_LEN), zero-extended to ACC_W. Timing is unchanged.
- Undefined: out_data = raw sum.

Decomposition:
- Shared header moa_defs.vh holds:
  - MOA_SUM_W=11
  - MOA_LAT=2
  - MOA_NUM_OPS=8
  - the ACC_W derivation expression
- These are reused by the adder, its bench and this block.
- Sub-module moa_valid_dly: parameterised MOA_LAT-deep valid shift register with async reset and sync clear.

Test Plan:
1. Reset, then in_valid high for 8 edges with constant operands giving summ=100, out_ready=1 → out_data=800, out_valid high for exactly 1 cycle, starting after edge k+9.
2. Operands x0..x7 = c+1,c+2,c+3,c+4,c+4,c+3,c+2,c+1 for c=0..7, so summ=8c+20 → out_data=384. With MOA_ACC_AVG_EN, out_data=48.
3. in_valid pattern 1,0,1,1,0,0,1,1,1,1,1 with summ=50, out_ready=1 → gaps do not count; one result of 400 after the 8th valid sample.
4. out_ready=0 across two complete blocks (summ=10 then summ=20) → out_data stays 80, overrun=1. Then raise out_ready → 80 transfers and out_valid falls.
5. clear asserted after 5 valid samples of summ=7, then 8 more samples → out_data=56 (not 91); overrun cleared.
6. rst_n dropped mid-block and mid-handshake (out_valid=1) → all outputs 0 immediately; the next full block gives the correct sum.
